// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default widths, named register indices and
// the writeback source select encoding.
package mips_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: one synchronous write port, two raw
// combinational read ports. Write qualification lives in the caller.
module regfile_core
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [NREGS];

   // Reset wins over a concurrent write so an in-flight WB value is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the WB value, commits it to the register file,
// serves two ID read ports with write-through bypass and counts retires.
module wb_regfile
   import mips_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              haveInstr,
   input  logic [DATA_W-1:0] readData,
   input  logic [DATA_W-1:0] ALUOut,
   input  logic [ADDR_W-1:0] regFromMux,
   input  logic              regWrite,
   input  logic              memToReg,
   input  logic [ADDR_W-1:0] rsAddr,
   input  logic [ADDR_W-1:0] rtAddr,
   output logic [DATA_W-1:0] rsData,
   output logic [DATA_W-1:0] rtData,
   output logic              wbRegWrite,
   output logic [ADDR_W-1:0] wbReg,
   output logic [DATA_W-1:0] wbData,
   output logic [CNT_W-1:0]  retiredCount
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

   logic              we;
   logic [DATA_W-1:0] wb_value;
   logic [DATA_W-1:0] raw_rs;
   logic [DATA_W-1:0] raw_rt;
   logic [CNT_W-1:0]  retired_q;
   wb_src_e           wb_src;

   // Index 0 is hard-wired, so the bypass must never forward into it either.
   function automatic logic [DATA_W-1:0] read_port(
      input logic [ADDR_W-1:0] idx,
      input logic [DATA_W-1:0] raw,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_idx,
      input logic [DATA_W-1:0] wr_data
   );
      if (idx == ZERO_IDX) begin
         return '0;
      end else if (wr_en && (idx == wr_idx)) begin
         return wr_data;
      end else begin
         return raw;
      end
   endfunction

   assign wb_src   = wb_src_e'(memToReg);
   assign wb_value = (wb_src == WB_SRC_MEM) ? readData : ALUOut;
   assign we       = regWrite & haveInstr & (regFromMux != ZERO_IDX);

   regfile_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .waddr   (regFromMux),
      .wdata   (wb_value),
      .raddr_a (rsAddr),
      .raddr_b (rtAddr),
      .rdata_a (raw_rs),
      .rdata_b (raw_rt)
   );

   assign rsData = read_port(rsAddr, raw_rs, we, regFromMux, wb_value);
   assign rtData = read_port(rtAddr, raw_rt, we, regFromMux, wb_value);

   assign wbRegWrite = we;
   assign wbReg      = regFromMux;
   assign wbData     = wb_value;

   // Counts every valid instruction reaching WB; wraps silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_q <= '0;
      end else if (haveInstr) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign retiredCount = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; the counter is narrowed to
// 4 bits so wraparound is reachable in a handful of cycles.
module tb_wb_regfile;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              haveInstr;
   logic [DATA_W-1:0] readData;
   logic [DATA_W-1:0] ALUOut;
   logic [ADDR_W-1:0] regFromMux;
   logic              regWrite;
   logic              memToReg;
   logic [ADDR_W-1:0] rsAddr;
   logic [ADDR_W-1:0] rtAddr;
   logic [DATA_W-1:0] rsData;
   logic [DATA_W-1:0] rtData;
   logic              wbRegWrite;
   logic [ADDR_W-1:0] wbReg;
   logic [DATA_W-1:0] wbData;
   logic [CNT_W-1:0]  retiredCount;

   int errors = 0;
   int checks = 0;

   wb_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .haveInstr    (haveInstr),
      .readData     (readData),
      .ALUOut       (ALUOut),
      .regFromMux   (regFromMux),
      .regWrite     (regWrite),
      .memToReg     (memToReg),
      .rsAddr       (rsAddr),
      .rtAddr       (rtAddr),
      .rsData       (rsData),
      .rtData       (rtData),
      .wbRegWrite   (wbRegWrite),
      .wbReg        (wbReg),
      .wbData       (wbData),
      .retiredCount (retiredCount)
   );

   always #5 clk = ~clk;

   // Inputs change on negedge, like the MEM/WB register upstream.
   task automatic idle_inputs();
      haveInstr  = 1'b0;
      regWrite   = 1'b0;
      memToReg   = 1'b0;
      readData   = '0;
      ALUOut     = '0;
      regFromMux = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      rsAddr = '0;
      rtAddr = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int i = 1; i < 32; i++) begin
         rsAddr = ADDR_W'(i);
         rtAddr = ADDR_W'(31 - i + 1);
         #1;
         checks++;
         if (rsData !== 32'h0) begin
            errors++;
            $display("FAIL reset_rs[%0d]: got %h expected %h", i, rsData, 32'h0);
         end
         checks++;
         if (rtData !== 32'h0) begin
            errors++;
            $display("FAIL reset_rt[%0d]: got %h expected %h", 32 - i, rtData, 32'h0);
         end
      end
      checks++;
      if (retiredCount !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", retiredCount);
      end
      checks++;
      if (wbRegWrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_wbRegWrite: got %b expected 0", wbRegWrite);
      end
   endtask

   task automatic test_alu_write();
      @(negedge clk);
      ALUOut     = 32'hDEADBEEF;
      readData   = 32'h0BAD0BAD;
      memToReg   = 1'b0;
      regWrite   = 1'b1;
      haveInstr  = 1'b1;
      regFromMux = 5'd8;
      rsAddr     = 5'd8;
      rtAddr     = 5'd9;
      #1;
      checks++;
      if (rsData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL alu_bypass_rs: got %h expected %h", rsData, 32'hDEADBEEF);
      end
      checks++;
      if (rtData !== 32'h0) begin
         errors++;
         $display("FAIL alu_other_rt: got %h expected %h", rtData, 32'h0);
      end
      checks++;
      if (wbRegWrite !== 1'b1 || wbReg !== 5'd8 || wbData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL alu_fwd_bus: got we=%b reg=%0d data=%h expected we=1 reg=8 data=deadbeef",
                  wbRegWrite, wbReg, wbData);
      end
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (rsData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL alu_storage_rs: got %h expected %h", rsData, 32'hDEADBEEF);
      end
      checks++;
      if (retiredCount !== 4'd1) begin
         errors++;
         $display("FAIL alu_count: got %0d expected 1", retiredCount);
      end
   endtask

   task automatic test_reg_zero();
      @(negedge clk);
      readData   = 32'h12345678;
      ALUOut     = 32'h55555555;
      memToReg   = 1'b1;
      regWrite   = 1'b1;
      haveInstr  = 1'b1;
      regFromMux = 5'd0;
      rsAddr     = 5'd0;
      rtAddr     = 5'd8;
      #1;
      checks++;
      if (wbRegWrite !== 1'b0) begin
         errors++;
         $display("FAIL r0_wbRegWrite: got %b expected 0", wbRegWrite);
      end
      checks++;
      if (wbData !== 32'h12345678) begin
         errors++;
         $display("FAIL r0_wbData_mem: got %h expected %h", wbData, 32'h12345678);
      end
      checks++;
      if (rsData !== 32'h0) begin
         errors++;
         $display("FAIL r0_rs_before: got %h expected %h", rsData, 32'h0);
      end
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (rsData !== 32'h0 || rtData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL r0_after: got rs=%h rt=%h expected rs=0 rt=deadbeef", rsData, rtData);
      end
      checks++;
      if (retiredCount !== 4'd2) begin
         errors++;
         $display("FAIL r0_count: got %0d expected 2", retiredCount);
      end
   endtask

   task automatic test_no_instr();
      @(negedge clk);
      ALUOut     = 32'd7;
      memToReg   = 1'b0;
      regWrite   = 1'b1;
      haveInstr  = 1'b0;
      regFromMux = 5'd5;
      rsAddr     = 5'd5;
      rtAddr     = 5'd5;
      #1;
      checks++;
      if (wbRegWrite !== 1'b0 || rsData !== 32'h0) begin
         errors++;
         $display("FAIL noinstr_during: got we=%b rs=%h expected we=0 rs=0", wbRegWrite, rsData);
      end
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (rtData !== 32'h0) begin
         errors++;
         $display("FAIL noinstr_storage: got %h expected %h", rtData, 32'h0);
      end
      checks++;
      if (retiredCount !== 4'd2) begin
         errors++;
         $display("FAIL noinstr_count: got %0d expected 2", retiredCount);
      end
   endtask

   task automatic test_dual_bypass();
      @(negedge clk);
      readData   = 32'hCAFEF00D;
      ALUOut     = 32'h11111111;
      memToReg   = 1'b1;
      regWrite   = 1'b1;
      haveInstr  = 1'b1;
      regFromMux = 5'd12;
      rsAddr     = 5'd12;
      rtAddr     = 5'd12;
      #1;
      checks++;
      if (rsData !== 32'hCAFEF00D || rtData !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL dual_bypass: got rs=%h rt=%h expected cafef00d both", rsData, rtData);
      end
      @(posedge clk);
      // Back-to-back overwrite of the same register from the ALU path.
      @(negedge clk);
      memToReg = 1'b0;
      ALUOut   = 32'h0000ABCD;
      rtAddr   = 5'd8;
      #1;
      checks++;
      if (rsData !== 32'h0000ABCD || rtData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL b2b_bypass: got rs=%h rt=%h expected rs=0000abcd rt=deadbeef", rsData, rtData);
      end
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (rsData !== 32'h0000ABCD) begin
         errors++;
         $display("FAIL b2b_storage: got %h expected %h", rsData, 32'h0000ABCD);
      end
      checks++;
      if (retiredCount !== 4'd4) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected 4", retiredCount);
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      ALUOut     = 32'hA;
      regWrite   = 1'b1;
      haveInstr  = 1'b1;
      regFromMux = 5'd3;
      @(posedge clk);
      @(negedge clk);
      ALUOut     = 32'hB;
      regFromMux = 5'd4;
      reset      = 1'b1;
      rsAddr     = 5'd4;
      rtAddr     = 5'd3;
      #1;
      checks++;
      if (rsData !== 32'hB || rtData !== 32'hA) begin
         errors++;
         $display("FAIL rst_hold_bypass: got rs=%h rt=%h expected rs=b rt=a", rsData, rtData);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if (rsData !== 32'h0 || rtData !== 32'h0) begin
         errors++;
         $display("FAIL rst_regs: got r4=%h r3=%h expected 0 both", rsData, rtData);
      end
      rsAddr = 5'd12;
      rtAddr = 5'd8;
      #1;
      checks++;
      if (rsData !== 32'h0 || rtData !== 32'h0) begin
         errors++;
         $display("FAIL rst_old_regs: got r12=%h r8=%h expected 0 both", rsData, rtData);
      end
      checks++;
      if (retiredCount !== 4'd0) begin
         errors++;
         $display("FAIL rst_count: got %0d expected 0", retiredCount);
      end
      haveInstr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (retiredCount !== 4'd1) begin
         errors++;
         $display("FAIL rst_first_retire: got %0d expected 1", retiredCount);
      end
   endtask

   task automatic test_count_wrap();
      @(negedge clk);
      haveInstr = 1'b1;
      regWrite  = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      haveInstr = 1'b0;
      #1;
      checks++;
      if (retiredCount !== 4'd15) begin
         errors++;
         $display("FAIL wrap_full: got %0d expected 15", retiredCount);
      end
      haveInstr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (retiredCount !== 4'd0) begin
         errors++;
         $display("FAIL wrap_zero: got %0d expected 0", retiredCount);
      end
   endtask

   initial begin
      reset  = 1'b1;
      rsAddr = '0;
      rtAddr = '0;
      idle_inputs();
      test_reset();
      test_alu_write();
      test_reg_zero();
      test_no_instr();
      test_dual_bypass();
      test_reset_midstream();
      test_count_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the pipelined MIPS datapath. It sits directly downstream of the MEM/WB pipeline register and selects the writeback value (memory read data or ALU result). It commits that value into a 32-entry register file and serves the two ID-stage read ports with write-through bypass. It also exports the writeback bus to the forwarding unit and counts retired instructions.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  reset, synchronous, active-high
- haveInstr  input  1  valid instruction present in WB (from MEM/WB)
- readData  input  DATA_W  memory load data (from MEM/WB)
- ALUOut  input  DATA_W  ALU result (from MEM/WB)
- regFromMux  input  ADDR_W  destination register index
- regWrite  input  1  write enable from WB control
- memToReg  input  1  1 selects readData, 0 selects ALUOut
- rsAddr  input  ADDR_W  ID read port A index
- rtAddr  input  ADDR_W  ID read port B index
- rsData  output  DATA_W  read port A data (combinational)
- rtData  output  DATA_W  read port B data (combinational)
- wbRegWrite  output  1  effective write enable to forwarding unit
- wbReg  output  ADDR_W  destination index to forwarding unit
- wbData  output  DATA_W  writeback value to forwarding unit
- retiredCount  output  CNT_W  instructions retired since reset

## Operation
- wbData = memToReg ? readData : ALUOut; combinational.
- Effective write: we = regWrite & haveInstr & (regFromMux != 0). wbRegWrite = we. wbReg = regFromMux.
- At posedge clk with we=1, reg[regFromMux] <= wbData. Otherwise reg is unchanged.
- Register 0 always reads 0. Writes to register 0 are discarded, and wbRegWrite stays 0 for them.
- Read ports are combinational:
  - Index 0 returns 0.
  - Otherwise, if we=1 and the index equals regFromMux, the port returns wbData (write-through bypass).
  - Otherwise the port returns reg[index].
- Both ports bypass independently. rsAddr == rtAddr == regFromMux bypasses both ports.
- retiredCount increments by 1 at each posedge with haveInstr=1, regardless of regWrite. It wraps from 2^CNT_W-1 to 0 silently.
- Reset, at posedge with reset=1:
  - All registers clear to 0, retiredCount clears to 0.
  - Any concurrent write and count are suppressed; reset has priority.
- While reset is held, rsData/rtData still show combinational bypass of wbData when we=1. Storage stays 0.

## Timing
- Write latency: 1 posedge. The value is visible from storage after that edge and from the bypass in the same cycle.
- MEM/WB updates on negedge, so WB inputs are stable before the posedge commit. ID reads in the second half of the cycle see the new value via bypass or storage.
- Reset values: all storage 0 and retiredCount 0. wbRegWrite, wbReg, and wbData are combinational functions of their inputs.
- Reset asserted mid-stream loses the in-flight WB write. After deassertion, the first posedge with haveInstr=1 makes retiredCount=1.

## Structure
- Shared package `mips_pkg`: DATA_W and ADDR_W defaults and the REG_ZERO constant (index 0). Add REG_SP/REG_RA constants if other stages need them.
- One natural sub-module is `regfile_core`: storage array, posedge write, two raw read ports.
- The wb_regfile top holds the writeback mux, write qualification, bypass logic and retire counter.

## Test plan
- Reset, then read all indices 1..31 on both ports -> all 0, and retiredCount=0.
- ALUOut=32'hDEADBEEF, memToReg=0, regWrite=1, haveInstr=1, regFromMux=8 -> during that cycle rsAddr=8 reads DEADBEEF via bypass. After the edge with inputs idle, it reads DEADBEEF from storage, and retiredCount=1.
- readData=32'h12345678, memToReg=1, regFromMux=0, regWrite=1 -> wbRegWrite=0; rsAddr=0 reads 0 before and after the edge.
- regWrite=1 with haveInstr=0, regFromMux=5, ALUOut=7 -> reg 5 stays 0 and retiredCount does not increment.
- Write 0xA to reg 3, then assert reset on the same edge as a write of 0xB to reg 4 -> regs 3 and 4 read 0 and retiredCount=0.
- Preload retiredCount to all-ones (force, or CNT_W overridden to 4 with 15 retires), then one more retire -> retiredCount=0.
